// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
// then one bit per clock is summed LSB-first by two cascaded half adders and
// a carry flip-flop. The result is transferred to sum/cout on the edge that
// processes the final bit, and a one-cycle done pulse follows.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds input 'sub'. With sub=1 the B operand is inverted and
//   the carry is preset to 1, giving a - b modulo 2^WIDTH (cout=1 -> no borrow).
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   start  in   request pulse, sampled only while idle
//   a, b   in   operands, sampled on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  result, held until overwritten by the next operation
//   cout   out  carry out of bit WIDTH-1, held with sum
// ---------------------------------------------------------------------------

// Combinational half adder used as the bit-slice building block.
//   i_x, i_y  in   addend bits
//   o_s       out  sum bit
//   o_c       out  carry bit
module halfadder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit so the counter can never wrap before reaching WIDTH-1.
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_load;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  logic             w_s0;
  logic             w_c0;
  logic             w_bit;
  logic             w_c1;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert B at load time, preset the carry.
  assign w_b_load = w_sub ? ~b : b;

  // ---------------------------------------------------------------------
  // Bit slice: two half adders plus the carry flip-flop form a full adder.
  // ---------------------------------------------------------------------
  halfadder u_ha0 (
    .i_x (r_a_sr[0]),
    .i_y (r_b_sr[0]),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  halfadder u_ha1 (
    .i_x (w_s0),
    .i_y (r_carry),
    .o_s (w_bit),
    .o_c (w_c1)
  );

  // The two half-adder carries can never both be 1, so OR is exact.
  assign w_carry_next = w_c0 | w_c1;

  // Result shifts in at the MSB; after WIDTH shifts it is fully aligned.
  assign w_res_next = {w_bit, r_res_sr[WIDTH-1:1]};

  assign w_last = (r_cnt == LAST_BIT);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ADD;
        end
      end
      S_ADD: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = start;
      end
      S_ADD: begin
        busy    = 1'b1;
        w_shift = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_load) begin
      // sum/cout intentionally keep the previous result here.
      r_a_sr   <= a;
      r_b_sr   <= w_b_load;
      r_res_sr <= '0;
      r_carry  <= w_sub;
      r_cnt    <= '0;
    end else if (w_shift) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res_sr <= w_res_next;
      r_carry  <= w_carry_next;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_carry_next;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed-vector bench for serial_adder (WIDTH=8). Expected results are
// pushed into a scoreboard queue at accept time; a monitor pops and compares
// on every done pulse. Define SERIAL_ADDER_SUB_EN to also cover subtraction.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;
  int cyc      = 0;

  logic [W:0] sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W:0] e;
      n_done = n_done + 1;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sum", int'(sum), int'(e[W-1:0]));
        check("cout", int'(cout), int'(e[W]));
      end
    end
  end

  // Drive an operation from a post-edge point while the DUT is idle.
  task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vsub, input logic [W-1:0] esum,
                        input logic ecout, input bit push);
    a     = va;
    b     = vb;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = vsub;
`else
    if (vsub) check("sub_unsupported", 1, 0);
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb_q.push_back({ecout, esum});
  endtask

  // Wait (bounded) for done; report edges waited and busy samples seen.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n = n + 1;
      if (done) return;
      if (busy) bc = bc + 1;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bc;
    int d0;
    int t_prev;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    step(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sum",  int'(sum),  0);
    check("rst_cout", int'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // 3 + 5: latency and busy width.
    accept(8'd3, 8'd5, 1'b0, 8'd8, 1'b0, 1'b1);
    wait_done(n, bc);
    check("latency", n, int'(W));
    check("busy_cycles", bc, int'(W));
    step(1);
    check("idle_after_done", int'(done), 0);

    // 255 + 1 wraps with carry, then 0 + 0.
    accept(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1);
    wait_done(n, bc);
    step(1);
    accept(8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("hold_cout_during_add", int'(cout), 1);
    d0 = n_done;
    wait_done(n, bc);
    step(1);
    check("second_done_pulse", n_done - d0, 1);

    // start during ADD and DONE ignored.
    d0 = n_done;
    accept(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b1);
    step(2);
    a     = 8'd99;
    b     = 8'd99;
    start = 1'b1;
    wait_done(n, bc);
    check("latency_ignored_start", n + 2, int'(W));
    step(1);
    start = 1'b0;
    check("busy_after_done_start", int'(busy), 0);
    step(12);
    check("single_done", n_done - d0, 1);
    check("sum_held", int'(sum), 30);

    // Reset mid-operation.
    d0 = n_done;
    accept(8'd200, 8'd100, 1'b0, 8'd0, 1'b0, 1'b0);
    step(3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_sum",  int'(sum),  0);
    check("abort_cout", int'(cout), 0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(12);
    check("abort_no_done", n_done - d0, 0);
    accept(8'd7, 8'd9, 1'b0, 8'd16, 1'b0, 1'b1);
    wait_done(n, bc);
    step(1);

    // Continuous start: one op every W+2 cycles.
    a      = 8'd1;
    b      = 8'd1;
    start  = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back({1'b0, 8'd2});
      wait_done(n, bc);
      if (k > 0) check("b2b_period", cyc - t_prev, int'(W) + 2);
      t_prev = cyc;
    end
    start = 1'b0;
    step(2);

`ifdef SERIAL_ADDER_SUB_EN
    accept(8'd5, 8'd3, 1'b1, 8'd2, 1'b1, 1'b1);
    wait_done(n, bc);
    step(1);
    accept(8'd3, 8'd5, 1'b1, 8'd254, 1'b0, 1'b1);
    wait_done(n, bc);
    step(1);
    accept(8'd3, 8'd5, 1'b0, 8'd8, 1'b0, 1'b1);
    wait_done(n, bc);
    step(1);
`endif

    step(2);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
